// File: rtl/switch_bounce_gen.sv
`default_nettype none
// ============================================================================
//  Module   : switch_bounce_gen
//  Purpose  : Turns a clean switch level into a contact-bounce waveform
//             (first edge, LFSR-timed chatter, settled level).
//  Revision : 1.0
// ============================================================================
module switch_bounce_gen #(
    parameter int          p_CNT_WIDTH  = 3,
    parameter int          p_GAP_WIDTH  = 4,
    parameter logic [15:0] p_SEED       = 16'hACE1,
    parameter logic        p_INIT_VALUE = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_clean,
    input  logic [p_CNT_WIDTH-1:0] iv_bounces,
    output logic                   o_bouncy,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [15:0] c_SEED = (p_SEED == 16'h0000) ? 16'h0001 : p_SEED;
    localparam int c_TW = p_CNT_WIDTH + 1;
    localparam int c_GW = p_GAP_WIDTH + 1;
    localparam logic [p_GAP_WIDTH-1:0] c_SETTLE = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [15:0]            lfsr_q,    lfsr_d;
    logic                   bouncy_q,  bouncy_d;
    logic                   level_q,   level_d;
    logic                   done_q,    done_d;
    logic [c_TW-1:0]        toggles_q, toggles_d;
    logic [c_GW-1:0]        gap_q,     gap_d;
    logic [p_GAP_WIDTH-1:0] settle_q,  settle_d;

    logic                   w_fb;
    logic [c_GW-1:0]        w_gap;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
    assign w_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_d = {w_fb, lfsr_q[15:1]};
    assign w_gap  = {1'b0, lfsr_q[p_GAP_WIDTH-1:0]} + c_GW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= c_SEED;
            bouncy_q  <= p_INIT_VALUE;
            level_q   <= p_INIT_VALUE;
            done_q    <= 1'b0;
            toggles_q <= '0;
            gap_q     <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bouncy_q  <= bouncy_d;
            level_q   <= level_d;
            done_q    <= done_d;
            toggles_q <= toggles_d;
            gap_q     <= gap_d;
            settle_q  <= settle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bouncy_d  = bouncy_q;
        level_d   = level_q;
        done_d    = 1'b0;
        toggles_d = toggles_q;
        gap_d     = gap_q;
        settle_d  = settle_q;
        case (state_q)
            S_IDLE: begin
                if (i_clean != level_q) begin
                    bouncy_d = i_clean;
                    level_d  = i_clean;
                    if (!i_enable || (iv_bounces == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        toggles_d = {iv_bounces, 1'b0};
                        gap_d     = w_gap;
                        state_d   = S_BOUNCE;
                    end
                end
            end
            S_BOUNCE: begin
                if (!i_enable) begin
                    bouncy_d = level_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (gap_q > c_GW'(1)) begin
                    gap_d = gap_q - c_GW'(1);
                end else begin
                    // Even toggle count, so the last toggle lands back on level_q.
                    bouncy_d  = ~bouncy_q;
                    toggles_d = toggles_q - c_TW'(1);
                    gap_d     = w_gap;
                    if (toggles_q == c_TW'(1)) begin
                        settle_d = c_SETTLE;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    settle_d = settle_q - p_GAP_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_bouncy = bouncy_q;
    assign o_done   = done_q;
    assign o_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire
